// File: rtl/gba_sound_mixer.sv
// gba_sound_mixer: sample-rate timer plus sequential PSG/DMA/bias mixer, clamped to 10-bit unsigned
module gba_sound_mixer #(
  parameter int BASE_PERIOD = 512,
  parameter int SAT_MAX     = 1023
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               gb_on_i,
  input  logic signed [15:0] ch_out_i [0:3],
  input  logic [3:0]         ch_on_i,
  input  logic [3:0]         psg_en_l_i,
  input  logic [3:0]         psg_en_r_i,
  input  logic [2:0]         psg_vol_l_i,
  input  logic [2:0]         psg_vol_r_i,
  input  logic [1:0]         psg_ratio_i,
  input  logic               dma_a_vol_i,
  input  logic               dma_b_vol_i,
  input  logic               dma_a_en_l_i,
  input  logic               dma_a_en_r_i,
  input  logic               dma_b_en_l_i,
  input  logic               dma_b_en_r_i,
  input  logic signed [7:0]  dma_a_sample_i,
  input  logic signed [7:0]  dma_b_sample_i,
  input  logic [9:0]         bias_level_i,
  input  logic [1:0]         bias_res_i,
  output logic [9:0]         sample_l_o,
  output logic [9:0]         sample_r_o,
  output logic               sample_valid_o,
  output logic               sample_tick_o
);
  localparam int CW = $clog2(BASE_PERIOD);
  typedef enum logic [2:0] {PSG0, PSG1, PSG2, PSG3, SCALE, DMA, BIAS, IDLE} state_e;
  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d, pm1;
  logic               tick_q, tick_d, valid_q, valid_d, wrap, start;
  logic [9:0]         smp_q [2];
  logic [9:0]         smp_d [2];
  logic signed [15:0] acc_q [2];
  logic signed [15:0] acc_d [2];
  logic signed [15:0] mul [2];
  logic signed [15:0] scl [2];
  logic signed [15:0] sum [2];
  logic signed [15:0] da, db, ch_sel;
  logic signed [15:0] ch_q [4];
  logic [3:0]         en_q [2];
  logic [2:0]         vol_q [2];
  logic [1:0]         dma_en_q [2];
  logic [1:0]         ratio_q;
  logic               dma_a_vol_q, dma_b_vol_q;
  logic signed [7:0]  dma_a_q, dma_b_q;
  logic [9:0]         bias_q;
  assign start = state_q == IDLE && tick_q;
  // Period counter; a shorter period after a bias_res change wraps on the very next edge
  always_comb begin
    pm1 = CW'((BASE_PERIOD >> bias_res_i) - 1);
    wrap = cnt_q >= pm1;
    cnt_d = (!gb_on_i || wrap) ? '0 : cnt_q + CW'(1);
    tick_d = gb_on_i && wrap;
  end
  // One adder per side: PSG terms, then volume/ratio scaling, then DMA, then bias and clamp
  always_comb begin
    ch_sel = ch_q[state_q[1:0]];
    da = {{8{dma_a_q[7]}}, dma_a_q} <<< (dma_a_vol_q ? 2 : 1);
    db = {{8{dma_b_q[7]}}, dma_b_q} <<< (dma_b_vol_q ? 2 : 1);
    for (int s = 0; s < 2; s++) begin
      mul[s] = acc_q[s] * $signed({13'd0, vol_q[s]} + 16'd1);
      scl[s] = ratio_q == 2'd2 ? mul[s] <<< 1 : ratio_q == 2'd1 ? mul[s] : mul[s] >>> 1;
      sum[s] = acc_q[s] + $signed({6'd0, bias_q});
      acc_d[s] = (!gb_on_i || state_q == IDLE) ? 16'sd0
               : state_q == SCALE ? scl[s]
               : state_q == DMA ? acc_q[s] + (dma_en_q[s][0] ? da : 16'sd0) + (dma_en_q[s][1] ? db : 16'sd0)
               : state_q == BIAS ? acc_q[s]
               : acc_q[s] + (en_q[s][state_q[1:0]] ? ch_sel : 16'sd0);
      smp_d[s] = !gb_on_i ? 10'h200
               : state_q != BIAS ? smp_q[s]
               : sum[s] < 0 ? 10'd0
               : sum[s] > 16'(SAT_MAX) ? 10'(SAT_MAX)
               : sum[s][9:0];
    end
    valid_d = gb_on_i && state_q == BIAS;
    state_d = !gb_on_i ? IDLE : (state_q == IDLE && !tick_q) ? IDLE : state_e'(state_q + 3'd1);
  end
  // Timer, mix sequencer and registered outputs
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      valid_q  <= 1'b0;
      state_q  <= IDLE;
      smp_q[0] <= 10'h200;
      smp_q[1] <= 10'h200;
      acc_q[0] <= '0;
      acc_q[1] <= '0;
    end else begin
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      valid_q <= valid_d;
      state_q <= state_d;
      smp_q   <= smp_d;
      acc_q   <= acc_d;
    end
  end
  // Input snapshot taken in the tick cycle so later input changes cannot disturb the mix
  always_ff @(posedge clk_i) begin
    if (gb_on_i && start) begin
      ch_q        <= ch_out_i;
      en_q[0]     <= ch_on_i & psg_en_l_i;
      en_q[1]     <= ch_on_i & psg_en_r_i;
      vol_q[0]    <= psg_vol_l_i;
      vol_q[1]    <= psg_vol_r_i;
      dma_en_q[0] <= {dma_b_en_l_i, dma_a_en_l_i};
      dma_en_q[1] <= {dma_b_en_r_i, dma_a_en_r_i};
      ratio_q     <= psg_ratio_i;
      dma_a_vol_q <= dma_a_vol_i;
      dma_b_vol_q <= dma_b_vol_i;
      dma_a_q     <= dma_a_sample_i;
      dma_b_q     <= dma_b_sample_i;
      bias_q      <= bias_level_i;
    end
  end
  assign sample_l_o     = smp_q[0];
  assign sample_r_o     = smp_q[1];
  assign sample_valid_o = valid_q;
  assign sample_tick_o  = tick_q;
endmodule

// File: tb/tb_gba_sound_mixer.sv
// tb_gba_sound_mixer: directed vector table plus timer/abort sequences for gba_sound_mixer
module tb_gba_sound_mixer;
  logic               clk, reset_n, gb_on;
  logic signed [15:0] ch [0:3];
  logic [3:0]         ch_on, en_l, en_r;
  logic [2:0]         vol_l, vol_r;
  logic [1:0]         ratio, bias_res;
  logic               a_vol, b_vol, a_en_l, a_en_r, b_en_l, b_en_r;
  logic signed [7:0]  a_smp, b_smp;
  logic [9:0]         bias, sample_l, sample_r;
  logic               sample_valid, sample_tick;
  int                 n_vec, n_bad;

  typedef struct {
    int c0, c1, c2, c3, on, el, er, vl, vr, rat;
    int sa, sb, av, bv, ael, aer, bel, ber, bias, xl, xr;
  } vec_t;
  vec_t tv [15];

  gba_sound_mixer dut (
    .clk_i(clk), .reset_n_i(reset_n), .gb_on_i(gb_on), .ch_out_i(ch), .ch_on_i(ch_on),
    .psg_en_l_i(en_l), .psg_en_r_i(en_r), .psg_vol_l_i(vol_l), .psg_vol_r_i(vol_r),
    .psg_ratio_i(ratio), .dma_a_vol_i(a_vol), .dma_b_vol_i(b_vol),
    .dma_a_en_l_i(a_en_l), .dma_a_en_r_i(a_en_r), .dma_b_en_l_i(b_en_l), .dma_b_en_r_i(b_en_r),
    .dma_a_sample_i(a_smp), .dma_b_sample_i(b_smp), .bias_level_i(bias), .bias_res_i(bias_res),
    .sample_l_o(sample_l), .sample_r_o(sample_r), .sample_valid_o(sample_valid), .sample_tick_o(sample_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_inputs(input vec_t v);
    ch[0] = 16'(v.c0); ch[1] = 16'(v.c1); ch[2] = 16'(v.c2); ch[3] = 16'(v.c3);
    ch_on = 4'(v.on); en_l = 4'(v.el); en_r = 4'(v.er);
    vol_l = 3'(v.vl); vol_r = 3'(v.vr); ratio = 2'(v.rat);
    a_smp = 8'(v.sa); b_smp = 8'(v.sb); a_vol = v.av[0]; b_vol = v.bv[0];
    a_en_l = v.ael[0]; a_en_r = v.aer[0]; b_en_l = v.bel[0]; b_en_r = v.ber[0];
    bias = 10'(v.bias);
  endtask

  // counts negedges up to and including the next tick; n=-1 on timeout
  task automatic watch_tick(output int n, output int nv);
    n = 0; nv = 0;
    do begin
      @(negedge clk);
      n++;
      if (sample_valid) nv++;
    end while (!sample_tick && n < 2000);
    if (!sample_tick) n = -1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_valid && n < 2000);
    if (!sample_valid) n = -1;
  endtask

  initial begin
    int n, m, nv;
    //        c0  c1  c2  c3 on el er vl vr rat  sa   sb av bv ael aer bel ber bias   xl    xr
    tv[0]  = '{  0,  0,  0,  0, 0, 0, 0, 0, 0, 0,    0,   0, 0, 0, 0, 0, 0, 0, 512,  512,  512};
    tv[1]  = '{  0,  0,  0, 15, 8, 8, 0, 7, 0, 2,    0,   0, 0, 0, 0, 0, 0, 0, 512,  752,  512};
    tv[2]  = '{ 15, 15, 15, 15,15,15, 0, 7, 0, 2,  127,   0, 1, 0, 1, 0, 0, 0, 512, 1023,  512};
    tv[3]  = '{-15,-15,-15,-15,15,15, 0, 7, 0, 2, -128,   0, 1, 0, 1, 0, 0, 0, 512,    0,  512};
    tv[4]  = '{ 15,  0,  0,  0, 1, 1, 1, 0, 1, 0,    0,   0, 0, 0, 0, 0, 0, 0, 512,  519,  527};
    tv[5]  = '{ 15,  0,  0,  0, 1, 1, 1, 0, 3, 1,    0,   0, 0, 0, 0, 0, 0, 0, 512,  527,  572};
    tv[6]  = '{ 15,  0,  0,  0, 1, 1, 1, 0, 7, 3,    0,   0, 0, 0, 0, 0, 0, 0, 512,  519,  572};
    tv[7]  = '{-15,  0,  0,  0, 1, 1, 1, 0, 0, 0,    0,   0, 0, 0, 0, 0, 0, 0, 512,  504,  504};
    tv[8]  = '{ 15,  0,  0,  0, 0, 1, 1, 7, 7, 2,    0,   0, 0, 0, 0, 0, 0, 0, 512,  512,  512};
    tv[9]  = '{  0,  0,  0,  0, 0, 0, 0, 0, 0, 0,  100, -50, 0, 1, 1, 0, 0, 1, 512,  712,  312};
    tv[10] = '{  0, 10, -5,  0, 6, 2, 4, 3, 1, 1,    0,   0, 0, 0, 0, 0, 0, 0, 512,  552,  502};
    tv[11] = '{ -1,  0,  0,  0, 1, 1, 0, 0, 0, 1,    0,   0, 0, 0, 0, 0, 0, 0,   0,    0,    0};
    tv[12] = '{  1,  0,  0,  0, 1, 0, 1, 0, 0, 1,    0,   0, 0, 0, 0, 0, 0, 0,1023, 1023, 1023};
    tv[13] = '{  0,  0,  0,  0, 0, 0, 0, 0, 0, 0, -128, 127, 0, 0, 1, 1, 1, 0, 512,  510,  256};
    tv[14] = '{ 15, 15,  0,  0, 3, 3, 1, 4, 2, 2,    0,   0, 0, 0, 0, 0, 0, 0, 512,  812,  602};
    n_vec = 0; n_bad = 0;
    clk = 0; reset_n = 0; gb_on = 1; bias_res = 2'd0;
    set_inputs(tv[0]);
    repeat (3) @(negedge clk);
    check("rst_L", int'(sample_l), 512);
    check("rst_R", int'(sample_r), 512);
    check("rst_valid", int'(sample_valid), 0);
    check("rst_tick", int'(sample_tick), 0);
    reset_n = 1;
    watch_tick(n, nv);
    check("first_tick_512", n, 512);
    wait_valid(n);
    check("tick_to_valid_8", n, 8);
    check("idle_L", int'(sample_l), 512);
    check("idle_R", int'(sample_r), 512);
    watch_tick(m, nv);
    check("period_512", n + m, 512);
    repeat (200) @(negedge clk);
    bias_res = 2'd3;
    @(negedge clk);
    check("tick_after_res_change", int'(sample_tick), 1);
    watch_tick(n, nv);
    check("period_64", n, 64);
    for (int i = 0; i < 15; i++) begin
      wait_valid(n);
      set_inputs(tv[i]);
      wait_valid(n);
      check($sformatf("vec%0d_valid_seen", i), int'(n > 0), 1);
      check($sformatf("vec%0d_L", i), int'(sample_l), tv[i].xl);
      check($sformatf("vec%0d_R", i), int'(sample_r), tv[i].xr);
    end
    wait_valid(n);
    set_inputs(tv[1]);
    watch_tick(n, nv);
    @(negedge clk);
    set_inputs(tv[2]);
    wait_valid(n);
    check("snapshot_L", int'(sample_l), 752);
    check("snapshot_R", int'(sample_r), 512);
    wait_valid(n);
    check("pre_abort_L", int'(sample_l), 1023);
    watch_tick(n, nv);
    repeat (3) @(negedge clk);
    reset_n = 0;
    #1;
    check("abort_rst_L", int'(sample_l), 512);
    check("abort_rst_valid", int'(sample_valid), 0);
    @(negedge clk);
    reset_n = 1;
    watch_tick(n, nv);
    check("rst_restart_64", n, 64);
    check("rst_no_valid", nv, 0);
    wait_valid(n);
    check("pre_gb_off_L", int'(sample_l), 1023);
    watch_tick(n, nv);
    repeat (2) @(negedge clk);
    gb_on = 0;
    @(negedge clk);
    check("gb_off_L", int'(sample_l), 512);
    check("gb_off_R", int'(sample_r), 512);
    check("gb_off_valid", int'(sample_valid), 0);
    check("gb_off_tick", int'(sample_tick), 0);
    repeat (3) @(negedge clk);
    gb_on = 1;
    watch_tick(n, nv);
    check("gb_restart_64", n, 64);
    check("gb_no_valid", nv, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
